// File: rtl/gauss_filter_imgwr_p.sv
// rtl/gauss_filter_imgwr_p.sv - Gauss filter image writer: tags filter beats with (x,y) and drives the frame-buffer write port
// Optional build macro GF_IMGWR_SKIP_PAD_EN: lead-in beats (p<0) are accepted and counted but never written.
module gauss_filter_imgwr_p #(
  parameter int DW    = 8,
  parameter int CW    = 10,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int LAT   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode_i,
  output logic          busy,
  output logic          finish,
  input  logic [DW-1:0] dt_i,
  input  logic          dv_i,
  output logic          rdy_o,
  output logic          wr_en_o,
  input  logic          wr_rdy_i,
  output logic [CW-1:0] wr_px_o,
  output logic [CW-1:0] wr_py_o,
  output logic [DW-1:0] wr_dt_o
);

  typedef enum logic [1:0] {IDLE, PASS0, PASS1, DONE} state_t;

  localparam logic [CW-1:0] P_FIRST = CW'(-LAT);
  localparam logic [CW-1:0] W_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] H_LAST  = CW'(IMG_H - 1);

  state_t        state, state_nx;
  logic [CW-1:0] pos, line;
  logic          mode;
  logic          in_pass, accept, pos_last, line_last, pass_end, frame_end, write_beat;
  logic [CW-1:0] beat_x, beat_y;

  always_comb begin
    in_pass   = (state == PASS0) || (state == PASS1);
    rdy_o     = in_pass && (!wr_en_o || wr_rdy_i);
    busy      = in_pass;
    // start takes priority: a beat offered in the start cycle is dropped
    accept    = dv_i && rdy_o && !start;
    pos_last  = (pos  == ((state == PASS1) ? H_LAST : W_LAST));
    line_last = (line == ((state == PASS1) ? W_LAST : H_LAST));
    pass_end  = accept && pos_last && line_last;
    frame_end = pass_end && ((state == PASS1) || !mode);
    beat_x    = (state == PASS1) ? line : pos;
    beat_y    = (state == PASS1) ? pos  : line;
`ifdef GF_IMGWR_SKIP_PAD_EN
    write_beat = accept && !pos[CW-1];
`else
    write_beat = accept;
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      PASS0:   if (pass_end) state_nx = mode ? PASS1 : DONE;
      PASS1:   if (pass_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (start) state_nx = PASS0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Scan counters restart at -LAT/0 at every pass boundary so PASS1 starts fresh
  always_ff @(posedge clk) begin
    if (rst) begin
      pos  <= P_FIRST;
      line <= '0;
      mode <= 1'b0;
    end else if (start) begin
      pos  <= P_FIRST;
      line <= '0;
      mode <= mode_i;
    end else if (accept) begin
      if (pos_last) begin
        pos  <= P_FIRST;
        line <= line_last ? '0 : line + 1'b1;
      end else begin
        pos <= pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) finish <= 1'b0;
    else     finish <= frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      wr_en_o <= 1'b0;
      wr_px_o <= '0;
      wr_py_o <= '0;
      wr_dt_o <= '0;
    end else if (write_beat) begin
      wr_en_o <= 1'b1;
      wr_px_o <= beat_x;
      wr_py_o <= beat_y;
      wr_dt_o <= dt_i;
    end else if (wr_rdy_i) begin
      wr_en_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gauss_filter_imgwr_p.sv
// tb/tb_gauss_filter_imgwr_p.sv - scoreboard bench for gauss_filter_imgwr_p (IMG_W=4, IMG_H=3, LAT=2)
module tb_gauss_filter_imgwr_p;
  localparam int DW  = 8;
  localparam int CW  = 10;
  localparam int W   = 4;
  localparam int H   = 3;
  localparam int LAT = 2;
  localparam int P0  = (W + LAT) * H;
  localparam int P1  = (H + LAT) * W;
  localparam int EW  = 2 * CW + DW;
`ifdef GF_IMGWR_SKIP_PAD_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, mode_i, busy, finish, dv_i, rdy_o, wr_en_o, wr_rdy_i;
  logic [DW-1:0] dt_i, wr_dt_o;
  logic [CW-1:0] wr_px_o, wr_py_o;

  int total = 0;
  int bad = 0;
  int fin_cnt = 0;
  logic [EW-1:0] sb[$];

  always #5 clk = ~clk;

  gauss_filter_imgwr_p #(.DW(DW), .CW(CW), .IMG_W(W), .IMG_H(H), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_i(mode_i), .busy(busy), .finish(finish),
    .dt_i(dt_i), .dv_i(dv_i), .rdy_o(rdy_o), .wr_en_o(wr_en_o), .wr_rdy_i(wr_rdy_i),
    .wr_px_o(wr_px_o), .wr_py_o(wr_py_o), .wr_dt_o(wr_dt_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] model(input int k, output bit pad);
    int l, p, px, py;
    if (k < P0) begin
      l = k / (W + LAT); p = k % (W + LAT) - LAT; px = p; py = l;
    end else begin
      l = (k - P0) / (H + LAT); p = (k - P0) % (H + LAT) - LAT; px = l; py = p;
    end
    pad = (p < 0);
    model = {CW'(px), CW'(py), DW'(k)};
  endfunction

  always @(negedge clk) begin
    if (finish) fin_cnt++;
    if (wr_en_o && wr_rdy_i) begin
      if (sb.size() == 0) check("unexpected_wr", 1, 0);
      else check("wr", {wr_px_o, wr_py_o, wr_dt_o}, sb.pop_front());
    end
  end

  task automatic do_start(input logic m, input logic dv);
    start = 1'b1; mode_i = m; dv_i = dv; dt_i = 8'hAA;
    @(posedge clk); #1;
    start = 1'b0; dv_i = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_beats(input int n, input int stall_at);
    int k = 0;
    int guard = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    bit pad;
    logic [EW-1:0] e;
    while (k < n && guard < 400) begin
      if (k == stall_at && !stalled) begin
        stalled = 1'b1; stall_left = 3;
      end
      wr_rdy_i = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      dv_i = 1'b1; dt_i = DW'(k);
      @(negedge clk);
      if (!wr_rdy_i) check("stall_rdy", rdy_o, 0);
      else check("rdy", rdy_o, 1);
      if (rdy_o) begin
        e = model(k, pad);
        if (!(SKIP && pad)) sb.push_back(e);
        k++;
      end
      @(posedge clk); #1;
      guard++;
    end
    dv_i = 1'b0; wr_rdy_i = 1'b1;
    if (k < n) check("timeout_beats", k, n);
  endtask

  task automatic frame_end(input logic [EW:0] last);
    @(negedge clk);
    check("finish", finish, 1);
    check("busy_done", busy, 0);
    check("last_wr", {wr_en_o, wr_px_o, wr_py_o, wr_dt_o}, last);
    @(posedge clk); #1;
    @(negedge clk);
    check("finish_pulse", finish, 0);
    @(posedge clk); #1;
    check("finish_count", fin_cnt, 1);
    check("sb_empty", sb.size(), 0);
    fin_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode_i = 1'b0; dv_i = 1'b0; dt_i = '0; wr_rdy_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_state", {busy, finish, wr_en_o, rdy_o, wr_px_o, wr_py_o, wr_dt_o}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single pass, back to back
    do_start(1'b0, 1'b0);
    send_beats(P0, -1);
    frame_end({1'b1, 10'd3, 10'd2, 8'd17});

    // two pass, transposed second pass
    do_start(1'b1, 1'b0);
    send_beats(P0 + P1, -1);
    frame_end({1'b1, 10'd3, 10'd2, 8'd37});

    // backpressure for 3 cycles mid-frame
    do_start(1'b0, 1'b0);
    send_beats(P0, 5);
    frame_end({1'b1, 10'd3, 10'd2, 8'd17});

    // restart after 7 beats; beat offered with start is dropped
    do_start(1'b0, 1'b0);
    send_beats(7, -1);
    do_start(1'b0, 1'b1);
    send_beats(P0, -1);
    frame_end({1'b1, 10'd3, 10'd2, 8'd17});

    // reset mid-frame, then dv_i ignored
    do_start(1'b0, 1'b0);
    send_beats(5, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid", {busy, finish, wr_en_o, wr_px_o, wr_py_o, wr_dt_o}, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      dv_i = 1'b1; dt_i = DW'(i);
      @(negedge clk);
      check("rdy_after_rst", rdy_o, 0);
      @(posedge clk); #1;
    end
    dv_i = 1'b0;
    @(negedge clk);
    check("wr_after_rst", wr_en_o, 0);
    check("sb_empty_rst", sb.size(), 0);
    check("finish_count_rst", fin_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
